multicycle_control_fsm: RTL and testbench

Multicycle control unit for the custom-opcode RISC-V-style core. It accepts instructions over a valid/ready fetch handshake, latches each one, and sequences it through FETCH/DECODE/EXEC/MEM/WB states. In each state it drives the datapath control strobes with the existing ALU control encodings. Over the single-cycle decoder it adds illegal-encoding detection, memory wait states with timeout, a retired-instruction counter, and a trap state.

---
 rtl/multicycle_control_fsm_if.sv | 36 +++
 rtl/multicycle_control_fsm.sv | 251 +++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Fetch handshake, memory handshake and datapath control bundle of the
// multicycle control unit. The FSM sits on the slave side; whatever feeds
// instructions and observes the strobes uses the master side.
interface multicycle_control_fsm_if #(
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic [31:0]      instr_in;
    logic             instr_ready;
    logic             mem_ready;
    logic             branch_taken;
    logic             pc_write;
    logic             pc_src;
    logic [3:0]       alu_control;
    logic             alu_src;
    logic             mem_to_reg;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic [1:0]       fault;
    logic             busy;
    logic [CNT_W-1:0] retire_count;
    logic [2:0]       state;

    modport master (
        output instr_valid, instr_in, mem_ready, branch_taken,
        input  instr_ready, pc_write, pc_src, alu_control, alu_src, mem_to_reg,
               reg_write, mem_read, mem_write, fault, busy, retire_count, state
    );

    modport slave (
        input  instr_valid, instr_in, mem_ready, branch_taken,
        output instr_ready, pc_write, pc_src, alu_control, alu_src, mem_to_reg,
               reg_write, mem_read, mem_write, fault, busy, retire_count, state
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: latches instructions from a valid/ready fetch
// port and walks each through FETCH/DECODE/EXEC/MEM/WB, driving datapath
// strobes, with illegal-opcode and memory-timeout traps.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   FETCH  | instr_ready high; handshake latches IR and bumps PC by 4
//   DECODE | classify IR; illegal encodings trap or are skipped
//   EXEC   | ALU op driven; branches resolve and retire here
//   MEM    | load/store held until mem_ready, bounded by MEM_TIMEOUT
//   WB     | one-cycle register write, instruction retires
//   TRAP   | all strobes quiet, fault held; only reset leaves
module multicycle_control_fsm #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15,
    parameter bit TRAP_HALT   = 1'b1
) (
    input logic                     clk_i,
    input logic                     reset_i,
    multicycle_control_fsm_if.slave bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {C_R, C_BR, C_SW, C_LW, C_LUI, C_I} cls_t;

    localparam logic [1:0] F_NONE    = 2'b00;
    localparam logic [1:0] F_ILLEGAL = 2'b01;
    localparam logic [1:0] F_TIMEOUT = 2'b10;
    // Compare against the count before increment: the MEM_TIMEOUT-th low cycle traps.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_q;
    cls_t             cls_q;
    logic [31:0]      ir_q;
    logic [7:0]       wait_q;
    logic [CNT_W-1:0] retire_q;
    logic [1:0]       fault_q;
    logic             instr_ready_q;
    logic             pc_src_q;
    logic [3:0]       alu_control_q;
    logic             alu_src_q;
    logic             mem_to_reg_q;
    logic             reg_write_q;
    logic             mem_read_q;
    logic             mem_write_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       bit30;
    logic       dec_legal;
    cls_t       dec_cls;
    logic [3:0] dec_alu;
    logic       dec_alu_src;
    logic       ir_unused;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign bit30  = ir_q[30];
    // Operand/register fields belong to the datapath, not to sequencing.
    assign ir_unused = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

    // Instruction class, ALU encoding and legality from the latched IR.
    always_comb begin
        dec_legal   = 1'b1;
        dec_cls     = C_R;
        dec_alu     = 4'b0000;
        dec_alu_src = 1'b0;
        case (opcode)
            7'b1110011: begin
                if (bit30) begin
                    dec_alu   = 4'b0101;
                    dec_legal = (funct3 == 3'b000);
                end else begin
                    case (funct3)
                        3'b000:  dec_alu = 4'b0000;
                        3'b001:  dec_alu = 4'b0110;
                        3'b010:  dec_alu = 4'b0001;
                        3'b100:  dec_alu = 4'b0010;
                        3'b101:  dec_alu = 4'b0011;
                        3'b110:  dec_alu = 4'b0100;
                        3'b111:  dec_alu = 4'b0111;
                        default: dec_legal = 1'b0;
                    endcase
                end
            end
            7'b1101011: begin
                dec_cls = C_BR;
                case (funct3)
                    3'b000:  dec_alu = 4'b1000;
                    3'b001:  dec_alu = 4'b1001;
                    default: dec_legal = 1'b0;
                endcase
            end
            7'b1100011, 7'b1000011: begin
                dec_cls     = (opcode == 7'b1000011) ? C_LW : C_SW;
                dec_alu     = 4'b0110;
                dec_alu_src = 1'b1;
                dec_legal   = (funct3 == 3'b010);
            end
            7'b0110000: begin
                dec_cls     = C_LUI;
                dec_alu     = 4'b1100;
                dec_alu_src = 1'b1;
            end
            7'b0011111: begin
                dec_cls     = C_I;
                dec_alu_src = 1'b1;
                case (funct3)
                    3'b000:  dec_alu = 4'b0110;
                    3'b001:  dec_alu = 4'b0001;
                    3'b010:  dec_alu = 4'b0010;
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Sequencer: next state plus the strobes that the next state presents.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_FETCH;
            cls_q         <= C_R;
            ir_q          <= '0;
            wait_q        <= '0;
            retire_q      <= '0;
            fault_q       <= F_NONE;
            instr_ready_q <= 1'b0;
            pc_src_q      <= 1'b0;
            alu_control_q <= 4'b0000;
            alu_src_q     <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
        end else begin
            instr_ready_q <= 1'b0;
            pc_src_q      <= 1'b0;
            alu_control_q <= 4'b0000;
            alu_src_q     <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            if (state_q != S_TRAP) fault_q <= F_NONE;
            case (state_q)
                S_FETCH: begin
                    instr_ready_q <= 1'b1;
                    if (bus.instr_valid && instr_ready_q) begin
                        ir_q          <= bus.instr_in;
                        instr_ready_q <= 1'b0;
                        state_q       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        cls_q         <= dec_cls;
                        alu_control_q <= dec_alu;
                        alu_src_q     <= dec_alu_src;
                        pc_src_q      <= (dec_cls == C_BR);
                        state_q       <= S_EXEC;
                    end else begin
                        fault_q <= F_ILLEGAL;
                        if (TRAP_HALT) begin
                            state_q <= S_TRAP;
                        end else begin
                            instr_ready_q <= 1'b1;
                            state_q       <= S_FETCH;
                        end
                    end
                end
                S_EXEC: begin
                    case (cls_q)
                        C_LW, C_SW: begin
                            wait_q        <= '0;
                            mem_read_q    <= (cls_q == C_LW);
                            mem_write_q   <= (cls_q == C_SW);
                            alu_control_q <= alu_control_q;
                            alu_src_q     <= alu_src_q;
                            state_q       <= S_MEM;
                        end
                        C_BR: begin
                            retire_q      <= retire_q + CNT_W'(1);
                            instr_ready_q <= 1'b1;
                            state_q       <= S_FETCH;
                        end
                        default: begin
                            reg_write_q <= 1'b1;
                            state_q     <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        if (cls_q == C_LW) begin
                            reg_write_q  <= 1'b1;
                            mem_to_reg_q <= 1'b1;
                            state_q      <= S_WB;
                        end else begin
                            retire_q      <= retire_q + CNT_W'(1);
                            instr_ready_q <= 1'b1;
                            state_q       <= S_FETCH;
                        end
                    end else begin
                        wait_q <= wait_q + 8'd1;
                        if (wait_q == WAIT_LAST) begin
                            fault_q <= F_TIMEOUT;
                            state_q <= S_TRAP;
                        end else begin
                            mem_read_q    <= mem_read_q;
                            mem_write_q   <= mem_write_q;
                            alu_control_q <= alu_control_q;
                            alu_src_q     <= alu_src_q;
                        end
                    end
                end
                S_WB: begin
                    retire_q      <= retire_q + CNT_W'(1);
                    instr_ready_q <= 1'b1;
                    state_q       <= S_FETCH;
                end
                S_TRAP: ;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Only the PC strobe looks at live inputs: the fetch handshake and the branch compare.
    assign bus.pc_write = ((state_q == S_FETCH) && bus.instr_valid && instr_ready_q) ||
                          ((state_q == S_EXEC) && (cls_q == C_BR) && bus.branch_taken);

    assign bus.instr_ready  = instr_ready_q;
    assign bus.pc_src       = pc_src_q;
    assign bus.alu_control  = alu_control_q;
    assign bus.alu_src      = alu_src_q;
    assign bus.mem_to_reg   = mem_to_reg_q;
    assign bus.reg_write    = reg_write_q;
    assign bus.mem_read     = mem_read_q;
    assign bus.mem_write    = mem_write_q;
    assign bus.fault        = fault_q;
    assign bus.busy         = (state_q != S_FETCH) && (state_q != S_TRAP);
    assign bus.retire_count = retire_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: one skipping instance (TRAP_HALT=0) and
// one halting instance, 4-bit retire counter, cycle-by-cycle expectations
// derived from the instruction-level behaviour.
module tb_multicycle_control_fsm;
    localparam int CW = 4;
    localparam int TMO = 15;
    localparam int C_R = 0, C_BR = 1, C_SW = 2, C_LW = 3, C_LUI = 4, C_I = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_fsm_if #(.CNT_W(CW)) d_if ();
    multicycle_control_fsm_if #(.CNT_W(CW)) h_if ();

    multicycle_control_fsm #(.CNT_W(CW), .MEM_TIMEOUT(TMO), .TRAP_HALT(1'b0)) dut (
        .clk_i(clk), .reset_i(reset), .bus(d_if.slave));
    multicycle_control_fsm #(.CNT_W(CW), .MEM_TIMEOUT(TMO), .TRAP_HALT(1'b1)) dut_h (
        .clk_i(clk), .reset_i(reset), .bus(h_if.slave));

    typedef struct packed {
        logic [2:0]    st;
        logic          rdy;
        logic          pcw;
        logic          pcs;
        logic [3:0]    alu;
        logic          alus;
        logic          m2r;
        logic          rw;
        logic          mr;
        logic          mw;
        logic [1:0]    flt;
        logic          busy;
        logic [CW-1:0] rc;
    } obs_t;

    int vectors = 0;
    int miscompares = 0;
    logic [CW-1:0] rc_m = '0;
    logic [1:0] pend_flt = 2'b00;

    function automatic obs_t base(input logic [2:0] st);
        obs_t o;
        o = '0;
        o.st = st;
        o.busy = (st != 3'd0) && (st != 3'd5);
        o.rc = rc_m;
        return o;
    endfunction

    function automatic obs_t pk0();
        obs_t o;
        o.st = d_if.state; o.rdy = d_if.instr_ready; o.pcw = d_if.pc_write;
        o.pcs = d_if.pc_src; o.alu = d_if.alu_control; o.alus = d_if.alu_src;
        o.m2r = d_if.mem_to_reg; o.rw = d_if.reg_write; o.mr = d_if.mem_read;
        o.mw = d_if.mem_write; o.flt = d_if.fault; o.busy = d_if.busy;
        o.rc = d_if.retire_count;
        return o;
    endfunction

    function automatic obs_t pkh();
        obs_t o;
        o.st = h_if.state; o.rdy = h_if.instr_ready; o.pcw = h_if.pc_write;
        o.pcs = h_if.pc_src; o.alu = h_if.alu_control; o.alus = h_if.alu_src;
        o.m2r = h_if.mem_to_reg; o.rw = h_if.reg_write; o.mr = h_if.mem_read;
        o.mw = h_if.mem_write; o.flt = h_if.fault; o.busy = h_if.busy;
        o.rc = h_if.retire_count;
        return o;
    endfunction

    // Instruction table: class, ALU encoding, immediate select, legality.
    function automatic void spec_decode(input logic [31:0] w, output bit legal,
                                        output int cls, output logic [3:0] alu,
                                        output bit alus);
        logic [6:0] op;
        logic [2:0] f3;
        op = w[6:0];
        f3 = w[14:12];
        legal = 1'b1; cls = C_R; alu = 4'b0000; alus = 1'b0;
        case (op)
            7'b1110011: begin
                if (w[30]) begin
                    legal = (f3 == 3'b000); alu = 4'b0101;
                end else begin
                    case (f3)
                        3'd0: alu = 4'b0000; 3'd1: alu = 4'b0110;
                        3'd2: alu = 4'b0001; 3'd4: alu = 4'b0010;
                        3'd5: alu = 4'b0011; 3'd6: alu = 4'b0100;
                        3'd7: alu = 4'b0111; default: legal = 1'b0;
                    endcase
                end
            end
            7'b1101011: begin
                cls = C_BR;
                if (f3 == 3'd0) alu = 4'b1000;
                else if (f3 == 3'd1) alu = 4'b1001;
                else legal = 1'b0;
            end
            7'b1100011: begin cls = C_SW; alu = 4'b0110; alus = 1'b1; legal = (f3 == 3'd2); end
            7'b1000011: begin cls = C_LW; alu = 4'b0110; alus = 1'b1; legal = (f3 == 3'd2); end
            7'b0110000: begin cls = C_LUI; alu = 4'b1100; alus = 1'b1; end
            7'b0011111: begin
                cls = C_I; alus = 1'b1;
                if (f3 == 3'd0) alu = 4'b0110;
                else if (f3 == 3'd1) alu = 4'b0001;
                else if (f3 == 3'd2) alu = 4'b0010;
                else legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
    endfunction

    task automatic check(input obs_t got, input obs_t exp, input string tag);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input obs_t e, input logic iv, input logic [31:0] ins,
                       input logic mr, input logic bt, input string tag);
        @(negedge clk);
        d_if.instr_valid = iv; d_if.instr_in = ins;
        d_if.mem_ready = mr; d_if.branch_taken = bt;
        #1;
        check(pk0(), e, tag);
    endtask

    task automatic hcyc(input obs_t e, input logic iv, input logic [31:0] ins, input string tag);
        @(negedge clk);
        h_if.instr_valid = iv; h_if.instr_in = ins;
        #1;
        check(pkh(), e, tag);
    endtask

    task automatic do_reset(input string tag);
        obs_t e;
        reset = 1'b1;
        rc_m = '0;
        pend_flt = 2'b00;
        e = base(3'd0);
        cyc(e, 1'b1, $urandom, 1'b0, 1'b1, {tag, ":reset"});
        reset = 1'b0;
        d_if.instr_valid = 1'b0;
    endtask

    task automatic idle(input string tag);
        obs_t e;
        e = base(3'd0); e.rdy = 1'b1; e.flt = pend_flt;
        cyc(e, 1'b0, $urandom, 1'($urandom), 1'($urandom), {tag, ":idle"});
        pend_flt = 2'b00;
    endtask

    // One instruction from handshake to return to FETCH. nwait >= TMO means
    // mem_ready never rises; abort_k >= 0 resets on that MEM cycle.
    task automatic run_instr(input logic [31:0] w, input logic bt, input int nwait,
                             input int abort_k, input string tag);
        obs_t e;
        bit legal, alus;
        int cls;
        logic [3:0] alu;
        e = base(3'd0); e.rdy = 1'b1; e.pcw = 1'b1; e.flt = pend_flt;
        cyc(e, 1'b1, w, 1'($urandom), 1'($urandom), {tag, ":fetch"});
        pend_flt = 2'b00;
        e = base(3'd1);
        cyc(e, 1'b1, $urandom, 1'($urandom), 1'($urandom), {tag, ":decode"});
        spec_decode(w, legal, cls, alu, alus);
        if (!legal) begin
            pend_flt = 2'b01;
            return;
        end
        e = base(3'd2); e.alu = alu; e.alus = alus;
        if (cls == C_BR) begin e.pcs = 1'b1; e.pcw = bt; end
        cyc(e, 1'b1, $urandom, 1'($urandom), bt, {tag, ":exec"});
        if (cls == C_BR) begin
            rc_m++;
            return;
        end
        if (cls == C_SW || cls == C_LW) begin
            for (int k = 0; k <= nwait && k < TMO; k++) begin
                if (k == abort_k) begin
                    do_reset(tag);
                    return;
                end
                e = base(3'd3); e.alu = alu; e.alus = alus;
                e.mr = (cls == C_LW); e.mw = (cls == C_SW);
                cyc(e, 1'b1, $urandom, (k == nwait), 1'($urandom), {tag, ":mem"});
            end
            if (nwait >= TMO) begin
                e = base(3'd5); e.flt = 2'b10;
                cyc(e, 1'b1, $urandom, 1'b1, 1'($urandom), {tag, ":trap"});
                cyc(e, 1'b1, $urandom, 1'b1, 1'($urandom), {tag, ":trap_hold"});
                return;
            end
            if (cls == C_SW) begin
                rc_m++;
                return;
            end
            e = base(3'd4); e.rw = 1'b1; e.m2r = 1'b1;
            cyc(e, 1'b1, $urandom, 1'($urandom), 1'($urandom), {tag, ":wb"});
            rc_m++;
            return;
        end
        e = base(3'd4); e.rw = 1'b1;
        cyc(e, 1'b1, $urandom, 1'($urandom), 1'($urandom), {tag, ":wb"});
        rc_m++;
    endtask

    initial begin
        obs_t e;
        logic [31:0] w;
        int nw;
        d_if.instr_valid = 1'b0; d_if.instr_in = '0; d_if.mem_ready = 1'b0; d_if.branch_taken = 1'b0;
        h_if.instr_valid = 1'b0; h_if.instr_in = '0; h_if.mem_ready = 1'b0; h_if.branch_taken = 1'b0;
        do_reset("init");

        // Halting instance: opcode 0 traps and stays there until reset.
        e = base(3'd0); e.rdy = 1'b1; e.pcw = 1'b1;
        hcyc(e, 1'b1, 32'h0, "halt:fetch");
        e = base(3'd1);
        hcyc(e, 1'b1, 32'h0, "halt:decode");
        for (int i = 0; i < 20; i++) begin
            e = base(3'd5); e.flt = 2'b01;
            hcyc(e, 1'b1, 32'h0, "halt:trap");
        end
        h_if.instr_valid = 1'b0;
        do_reset("halt");
        e = base(3'd0); e.rdy = 1'b1;
        hcyc(e, 1'b0, 32'h0, "halt:after_reset");

        run_instr(32'h00000073, 1'b0, 0, -1, "add");
        run_instr(32'h40000073, 1'b0, 0, -1, "sub");
        idle("after_add_sub");
        run_instr(32'h00002043, 1'b0, 3, -1, "lw_w3");
        run_instr(32'h0000006B, 1'b1, 0, -1, "beq_taken");
        run_instr(32'h0000006B, 1'b0, 0, -1, "beq_not");
        run_instr(32'h0000106B, 1'b1, 0, -1, "bne_taken");
        run_instr(32'h00000000, 1'b0, 0, -1, "illegal_skip");
        idle("skip_pulse");
        idle("skip_clear");
        run_instr(32'h40001073, 1'b0, 0, -1, "r_bit30_bad");
        run_instr(32'h0000001F, 1'b0, 0, -1, "addi");
        run_instr(32'h0000101F, 1'b0, 0, -1, "i_f1");
        run_instr(32'h0000201F, 1'b0, 0, -1, "i_f2");
        run_instr(32'h12345030, 1'b0, 0, -1, "lui");
        run_instr(32'h00002063, 1'b0, TMO - 1, -1, "sw_last_cycle");
        run_instr(32'h00002063, 1'b0, 999, -1, "sw_timeout");
        do_reset("after_timeout");
        run_instr(32'h00002043, 1'b0, 5, 2, "lw_abort");
        for (int i = 0; i < 16; i++) run_instr(32'h00000030 | ($urandom & 32'hFFFF_F000), 1'b0, 0, -1, "lui_wrap");
        idle("wrapped");

        for (int n = 0; n < 200; n++) begin
            w = $urandom;
            case ($urandom_range(0, 6))
                0: w[6:0] = 7'b1110011;
                1: w[6:0] = 7'b1101011;
                2: w[6:0] = 7'b1100011;
                3: w[6:0] = 7'b1000011;
                4: w[6:0] = 7'b0110000;
                5: w[6:0] = 7'b0011111;
                default: ;
            endcase
            if ((w[6:0] == 7'b1100011 || w[6:0] == 7'b1000011) && $urandom_range(0, 3) != 0)
                w[14:12] = 3'b010;
            if (w[6:0] == 7'b1110011 && $urandom_range(0, 1) == 0) w[30] = 1'b0;
            nw = ($urandom_range(0, 9) == 0) ? TMO - 1 : $urandom_range(0, 4);
            run_instr(w, 1'($urandom), nw, -1, "rand");
            for (int k = $urandom_range(0, 2); k > 0; k--) idle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
